// File: rtl/writeback_unit_pkg.sv
// writeback_unit_pkg: load funct3 codes and FSM state encodings shared by the writeback slice.
package writeback_unit_pkg;
   localparam logic [2:0] LD_LB  = 3'b000;
   localparam logic [2:0] LD_LH  = 3'b001;
   localparam logic [2:0] LD_LW  = 3'b010;
   localparam logic [2:0] LD_LBU = 3'b100;
   localparam logic [2:0] LD_LHU = 3'b101;
   localparam logic [0:0] ST_IDLE     = 1'b0;
   localparam logic [0:0] ST_WAIT_MEM = 1'b1;
endpackage

// File: rtl/writeback_unit_align.sv
// load_align: selects the byte/halfword lane of a load word and sign/zero-extends it.
module load_align
   import writeback_unit_pkg::*;
(
   input  logic [2:0]  funct3_i,
   input  logic [1:0]  addr_lo_i,
   input  logic [31:0] rdata_i,
   output logic [31:0] data_o
);
   logic [15:0] half;
   logic [7:0]  byte_v;
   assign half   = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];
   assign byte_v = addr_lo_i[0] ? half[15:8] : half[7:0];
   assign data_o = funct3_i == LD_LW  ? rdata_i :
                   funct3_i == LD_LB  ? {{24{byte_v[7]}}, byte_v} :
                   funct3_i == LD_LH  ? {{16{half[15]}}, half} :
                   funct3_i == LD_LBU ? {24'b0, byte_v} :
                   funct3_i == LD_LHU ? {16'b0, half} : rdata_i;
endmodule

// File: rtl/writeback_unit.sv
// writeback_unit: merges ALU results and load responses onto the register-file write port.
// Optional load timeout enabled by defining WB_TIMEOUT_EN.
module writeback_unit
   import writeback_unit_pkg::*;
#(
   parameter int LOAD_TIMEOUT = 16
)(
   input  logic        I_clk,
   input  logic        I_rst,
   input  logic        I_alu_valid,
   input  logic [3:0]  I_alu_rd,
   input  logic [31:0] I_alu_data,
   input  logic        I_ld_valid,
   input  logic [3:0]  I_ld_rd,
   input  logic [2:0]  I_ld_funct3,
   input  logic [1:0]  I_ld_addr_lo,
   input  logic        I_mem_rvalid,
   input  logic [31:0] I_mem_rdata,
   output logic        O_ld_ready,
   output logic        O_stall,
   output logic        O_pend_valid,
   output logic [3:0]  O_pend_rd,
   output logic        O_regwen,
   output logic [3:0]  O_rd,
   output logic [31:0] O_data,
   output logic        O_ld_err
);
   if (LOAD_TIMEOUT < 2) begin : g_cfg_chk
      $error("LOAD_TIMEOUT must be >= 2");
   end
   logic [0:0]  state_q, state_d;
   logic [3:0]  pend_rd_q, pend_rd_d, skid_rd_q, skid_rd_d, rd_q, rd_d;
   logic [2:0]  f3_q, f3_d;
   logic [1:0]  lo_q, lo_d;
   logic        skid_v_q, skid_v_d, regwen_q, regwen_d;
   logic [31:0] skid_data_q, skid_data_d, data_q, data_d, ld_data;
   logic        resp, tmo, ld_acc, ld_wr, alu_acc;
   load_align u_align (.funct3_i(f3_q), .addr_lo_i(lo_q), .rdata_i(I_mem_rdata), .data_o(ld_data));
   assign O_ld_ready   = state_q == ST_IDLE && !skid_v_q;
   assign O_stall      = skid_v_q;
   assign O_pend_valid = state_q == ST_WAIT_MEM;
   assign O_pend_rd    = pend_rd_q;
   assign O_regwen     = regwen_q;
   assign O_rd         = rd_q;
   assign O_data       = data_q;
   assign resp    = state_q == ST_WAIT_MEM && I_mem_rvalid;
   assign ld_acc  = I_ld_valid && O_ld_ready;
   assign ld_wr   = (resp || tmo) && pend_rd_q != 4'd0;
   assign alu_acc = I_alu_valid && !skid_v_q && I_alu_rd != 4'd0;
`ifdef WB_TIMEOUT_EN
   localparam int CW = $clog2(LOAD_TIMEOUT);
   logic [CW-1:0] cnt_q, cnt_d;
   logic          err_q;
   assign tmo      = state_q == ST_WAIT_MEM && !I_mem_rvalid && cnt_q == CW'(LOAD_TIMEOUT - 1);
   assign cnt_d    = (state_q == ST_WAIT_MEM && !resp && !tmo) ? cnt_q + 1'b1 : '0;
   assign O_ld_err = err_q;
   always_ff @(posedge I_clk or posedge I_rst) begin
      if (I_rst) begin
         cnt_q <= '0;
         err_q <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         err_q <= tmo;
      end
   end
`else
   assign tmo      = 1'b0;
   assign O_ld_err = 1'b0;
`endif
   // Load response outranks the skid, which outranks a fresh ALU result.
   always_comb begin
      state_d     = ld_acc ? ST_WAIT_MEM : (resp || tmo) ? ST_IDLE : state_q;
      pend_rd_d   = ld_acc ? I_ld_rd : pend_rd_q;
      f3_d        = ld_acc ? I_ld_funct3 : f3_q;
      lo_d        = ld_acc ? I_ld_addr_lo : lo_q;
      skid_v_d    = ld_wr && (skid_v_q || alu_acc);
      skid_rd_d   = (ld_wr && alu_acc) ? I_alu_rd : skid_rd_q;
      skid_data_d = (ld_wr && alu_acc) ? I_alu_data : skid_data_q;
      regwen_d    = ld_wr || skid_v_q || alu_acc;
      rd_d        = ld_wr ? pend_rd_q : skid_v_q ? skid_rd_q : alu_acc ? I_alu_rd : rd_q;
      data_d      = ld_wr ? (resp ? ld_data : 32'd0) : skid_v_q ? skid_data_q : alu_acc ? I_alu_data : data_q;
   end
   always_ff @(posedge I_clk or posedge I_rst) begin
      if (I_rst) begin
         state_q     <= ST_IDLE;
         pend_rd_q   <= '0;
         f3_q        <= '0;
         lo_q        <= '0;
         skid_v_q    <= 1'b0;
         skid_rd_q   <= '0;
         skid_data_q <= '0;
         regwen_q    <= 1'b0;
         rd_q        <= '0;
         data_q      <= '0;
      end else begin
         state_q     <= state_d;
         pend_rd_q   <= pend_rd_d;
         f3_q        <= f3_d;
         lo_q        <= lo_d;
         skid_v_q    <= skid_v_d;
         skid_rd_q   <= skid_rd_d;
         skid_data_q <= skid_data_d;
         regwen_q    <= regwen_d;
         rd_q        <= rd_d;
         data_q      <= data_d;
      end
   end
endmodule
